i2c_lpc_reg_arbiter: RTL and testbench

//  Shares the I2C1 register-bank bus (port_cs/offset_sel/rd_wr/data) between the I2C slave engine
//  and the LPC host port. Each requester makes one 8-bit access per request, using a level-req/pulse-ack

---
 rtl/i2c_arb_pkg.sv | 21 ++
 rtl/i2c_arb_lock_timer.sv | 44 ++++
 rtl/i2c_lpc_reg_arbiter.sv | 164 ++++++++++++++++
 tb/tb_i2c_lpc_reg_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the I2C/LPC register-bank bus arbiter.
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StDone,
      StReject
   } arb_state_e;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_I2C  = 2'b01;
   localparam logic [1:0] OWN_LPC  = 2'b10;

   localparam logic [7:0] RD_ERR_DATA = 8'hFF;

   function automatic logic onehot16(input logic [15:0] v);
      return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
   endfunction

endpackage

// File: rtl/i2c_arb_lock_timer.sv
// Bounds how long an I2C multi-byte lock may hold off a pending LPC request.
// Instantiated only when I2C_ARB_LOCK_EN is defined.
module i2c_arb_lock_timer #(
   parameter int unsigned LOCK_TMO = 25000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic lock_i,
   input  logic owner_i2c_i,
   input  logic lpc_req_i,
   output logic block_o,
   output logic tmo_o
);

   logic [31:0] cnt_q;
   logic        ignore_q;
   logic        tmo_q;
   logic        lock_active;

   // Once timed out, the lock stays ineffective until i2c_lock is released.
   assign lock_active = lock_i && owner_i2c_i && !ignore_q;
   assign block_o     = lock_active;
   assign tmo_o       = tmo_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q    <= 32'd0;
         ignore_q <= 1'b0;
         tmo_q    <= 1'b0;
      end else if (!lock_i) begin
         cnt_q    <= 32'd0;
         ignore_q <= 1'b0;
      end else if (lock_active && lpc_req_i) begin
         if (cnt_q == 32'(LOCK_TMO - 1)) begin
            cnt_q    <= 32'd0;
            ignore_q <= 1'b1;
            tmo_q    <= 1'b1;
         end else begin
            cnt_q <= cnt_q + 32'd1;
         end
      end
   end

endmodule

// File: rtl/i2c_lpc_reg_arbiter.sv
// Round-robin arbiter sharing the I2C1 register-bank bus between the I2C slave and LPC host.
// Optional I2C lock with timeout is enabled by defining I2C_ARB_LOCK_EN.
module i2c_lpc_reg_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned LOCK_TMO = 25000
) (
   input  logic        CPLD_25M_CLK,
   input  logic        rst,
   input  logic        i2c_req,
   input  logic        i2c_rd_wr,
   input  logic [15:0] i2c_port_cs,
   input  logic [15:0] i2c_offset_sel,
   input  logic [7:0]  i2c_wdata,
   input  logic        i2c_lock,
   output logic        i2c_ack,
   output logic [7:0]  i2c_rdata,
   input  logic        lpc_req,
   input  logic        lpc_rd_wr,
   input  logic [15:0] lpc_port_cs,
   input  logic [15:0] lpc_offset_sel,
   input  logic [7:0]  lpc_wdata,
   output logic        lpc_ack,
   output logic [7:0]  lpc_rdata,
   output logic        rd_wr,
   output logic [15:0] port_cs,
   output logic [15:0] offset_sel,
   output logic [7:0]  wdata,
   input  logic [7:0]  bus_rdata,
   output logic [1:0]  owner,
   output logic [7:0]  err_cnt,
   output logic        lock_tmo
);

   localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   arb_state_e  state_q;
   logic [1:0]  owner_q, last_owner_q;
   logic [CntW-1:0] lat_cnt_q;
   logic        i2c_ack_q, lpc_ack_q;
   logic [7:0]  i2c_rdata_q, lpc_rdata_q;
   logic        rd_wr_q;
   logic [15:0] port_cs_q, offset_sel_q;
   logic [7:0]  wdata_q;
   logic [7:0]  err_cnt_q;

   logic        lpc_block;
   logic        lpc_pend, grant_i2c, grant_lpc;
   logic        sel_rd_wr;
   logic [15:0] sel_cs, sel_off;
   logic [7:0]  sel_wdata;

`ifdef I2C_ARB_LOCK_EN
   i2c_arb_lock_timer #(
      .LOCK_TMO(LOCK_TMO)
   ) u_lock_timer (
      .clk_i       (CPLD_25M_CLK),
      .rst_i       (rst),
      .lock_i      (i2c_lock),
      .owner_i2c_i (last_owner_q == OWN_I2C),
      .lpc_req_i   (lpc_req),
      .block_o     (lpc_block),
      .tmo_o       (lock_tmo)
   );
`else
   logic unused_lock_cfg;
   assign unused_lock_cfg = i2c_lock ^ (LOCK_TMO == 0);
   assign lpc_block = 1'b0;
   assign lock_tmo  = 1'b0;
`endif

   // On a tie the requester that did not own the bus last wins.
   assign lpc_pend  = lpc_req && !lpc_block;
   assign grant_i2c = i2c_req && (!lpc_pend || (last_owner_q == OWN_LPC));
   assign grant_lpc = lpc_pend && !grant_i2c;

   assign sel_rd_wr = grant_lpc ? lpc_rd_wr      : i2c_rd_wr;
   assign sel_cs    = grant_lpc ? lpc_port_cs    : i2c_port_cs;
   assign sel_off   = grant_lpc ? lpc_offset_sel : i2c_offset_sel;
   assign sel_wdata = grant_lpc ? lpc_wdata      : i2c_wdata;

   always_ff @(posedge CPLD_25M_CLK or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= OWN_NONE;
         last_owner_q <= OWN_LPC;
         lat_cnt_q    <= '0;
         i2c_ack_q    <= 1'b0;
         lpc_ack_q    <= 1'b0;
         i2c_rdata_q  <= 8'h00;
         lpc_rdata_q  <= 8'h00;
         rd_wr_q      <= 1'b0;
         port_cs_q    <= 16'd0;
         offset_sel_q <= 16'd0;
         wdata_q      <= 8'h00;
         err_cnt_q    <= 8'h00;
      end else begin
         i2c_ack_q <= 1'b0;
         lpc_ack_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (grant_i2c || grant_lpc) begin
                  owner_q <= grant_i2c ? OWN_I2C : OWN_LPC;
                  if (onehot16(sel_cs) && onehot16(sel_off)) begin
                     state_q      <= StAccess;
                     rd_wr_q      <= sel_rd_wr;
                     port_cs_q    <= sel_cs;
                     offset_sel_q <= sel_off;
                     wdata_q      <= sel_wdata;
                     lat_cnt_q    <= CntW'(RD_LAT - 1);
                  end else begin
                     // Malformed select: answer with error data, never touch the banks.
                     state_q <= StReject;
                     if (grant_i2c) begin
                        i2c_ack_q   <= 1'b1;
                        i2c_rdata_q <= RD_ERR_DATA;
                     end else begin
                        lpc_ack_q   <= 1'b1;
                        lpc_rdata_q <= RD_ERR_DATA;
                     end
                     if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                  end
               end
            end
            StAccess: begin
               if (lat_cnt_q == '0) begin
                  state_q      <= StDone;
                  rd_wr_q      <= 1'b0;
                  port_cs_q    <= 16'd0;
                  offset_sel_q <= 16'd0;
                  if (owner_q == OWN_I2C) begin
                     i2c_ack_q <= 1'b1;
                     if (!rd_wr_q) i2c_rdata_q <= bus_rdata;
                  end else begin
                     lpc_ack_q <= 1'b1;
                     if (!rd_wr_q) lpc_rdata_q <= bus_rdata;
                  end
               end else begin
                  lat_cnt_q <= lat_cnt_q - CntW'(1);
               end
            end
            StDone, StReject: begin
               state_q      <= StIdle;
               last_owner_q <= owner_q;
               owner_q      <= OWN_NONE;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign i2c_ack    = i2c_ack_q;
   assign lpc_ack    = lpc_ack_q;
   assign i2c_rdata  = i2c_rdata_q;
   assign lpc_rdata  = lpc_rdata_q;
   assign rd_wr      = rd_wr_q;
   assign port_cs    = port_cs_q;
   assign offset_sel = offset_sel_q;
   assign wdata      = wdata_q;
   assign owner      = owner_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_i2c_lpc_reg_arbiter.sv
// Self-checking bench for i2c_lpc_reg_arbiter: vector table, tie/lock/reset sequences,
// and an ack scoreboard.
module tb_i2c_lpc_reg_arbiter;

   localparam int unsigned RdLat   = 1;
   localparam int unsigned LockTmo = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i2c_req = 1'b0, i2c_rd_wr = 1'b0, i2c_lock = 1'b0;
   logic [15:0] i2c_port_cs = '0, i2c_offset_sel = '0;
   logic [7:0]  i2c_wdata = '0;
   logic        i2c_ack;
   logic [7:0]  i2c_rdata;
   logic        lpc_req = 1'b0, lpc_rd_wr = 1'b0;
   logic [15:0] lpc_port_cs = '0, lpc_offset_sel = '0;
   logic [7:0]  lpc_wdata = '0;
   logic        lpc_ack;
   logic [7:0]  lpc_rdata;
   logic        rd_wr;
   logic [15:0] port_cs, offset_sel;
   logic [7:0]  wdata;
   logic [7:0]  bus_rdata = '0;
   logic [1:0]  owner;
   logic [7:0]  err_cnt;
   logic        lock_tmo;

   always #5 clk = ~clk;

   i2c_lpc_reg_arbiter #(
      .RD_LAT   (RdLat),
      .LOCK_TMO (LockTmo)
   ) dut (
      .CPLD_25M_CLK   (clk),
      .rst            (rst),
      .i2c_req        (i2c_req),
      .i2c_rd_wr      (i2c_rd_wr),
      .i2c_port_cs    (i2c_port_cs),
      .i2c_offset_sel (i2c_offset_sel),
      .i2c_wdata      (i2c_wdata),
      .i2c_lock       (i2c_lock),
      .i2c_ack        (i2c_ack),
      .i2c_rdata      (i2c_rdata),
      .lpc_req        (lpc_req),
      .lpc_rd_wr      (lpc_rd_wr),
      .lpc_port_cs    (lpc_port_cs),
      .lpc_offset_sel (lpc_offset_sel),
      .lpc_wdata      (lpc_wdata),
      .lpc_ack        (lpc_ack),
      .lpc_rdata      (lpc_rdata),
      .rd_wr          (rd_wr),
      .port_cs        (port_cs),
      .offset_sel     (offset_sel),
      .wdata          (wdata),
      .bus_rdata      (bus_rdata),
      .owner          (owner),
      .err_cnt        (err_cnt),
      .lock_tmo       (lock_tmo)
   );

   typedef struct {
      logic        who;   // 0 = I2C, 1 = LPC
      logic        rd_wr;
      logic [15:0] cs;
      logic [15:0] off;
      logic [7:0]  wd;
      logic [7:0]  bus;
      logic [7:0]  exp_rdata;
      logic        rej;
      logic [7:0]  exp_err;
   } vec_t;

   typedef struct {
      logic       who;
      logic [7:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   logic bus_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (port_cs != 16'd0) bus_seen = 1'b1;
      if (!rst && (i2c_ack || lpc_ack)) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", {30'd0, i2c_ack, lpc_ack}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("ack_who", {30'd0, i2c_ack, lpc_ack}, e.who ? 32'd1 : 32'd2);
            check("ack_rdata", e.who ? lpc_rdata : i2c_rdata, e.rdata);
         end
      end
   end

   task automatic drive(input vec_t v);
      bus_rdata = v.bus;
      if (!v.who) begin
         i2c_rd_wr = v.rd_wr; i2c_port_cs = v.cs; i2c_offset_sel = v.off;
         i2c_wdata = v.wd;    i2c_req = 1'b1;
      end else begin
         lpc_rd_wr = v.rd_wr; lpc_port_cs = v.cs; lpc_offset_sel = v.off;
         lpc_wdata = v.wd;    lpc_req = 1'b1;
      end
   endtask

   task automatic wait_ack(input logic who, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(who ? lpc_ack : i2c_ack) && n < 40);
      if (!(who ? lpc_ack : i2c_ack)) check("ack_timeout", {31'd0, who ? lpc_ack : i2c_ack}, 1);
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      drive(v);
      sb.push_back('{who: v.who, rdata: v.exp_rdata});
      if (!v.rej) begin
         for (int k = 0; k < RdLat; k++) begin
            @(negedge clk);
            check("acc_owner", owner, v.who ? 32'd2 : 32'd1);
            check("acc_port_cs", port_cs, v.cs);
            check("acc_offset", offset_sel, v.off);
            check("acc_rd_wr", rd_wr, v.rd_wr);
            if (v.rd_wr) check("acc_wdata", wdata, v.wd);
         end
      end
      wait_ack(v.who, n);
      check("ack_latency", n, 1);
      check("ack_port_cs", port_cs, 0);
      check("err_cnt", err_cnt, v.exp_err);
      if (!v.who) i2c_req = 1'b0; else lpc_req = 1'b0;
      @(negedge clk);
      check("idle_owner", owner, 0);
   endtask

   // Both request in the same cycle; expectations are pushed in the order they must be served.
   task automatic tie(input vec_t vi, input vec_t vl, input logic [1:0] first_owner);
      int got_i = 0, got_l = 0, n = 0;
      drive(vi);
      drive(vl);
      sb.push_back('{who: 1'b0, rdata: vi.exp_rdata});
      sb.push_back('{who: 1'b1, rdata: vl.exp_rdata});
      @(negedge clk);
      check("tie_first_owner", owner, first_owner);
      while ((got_i == 0 || got_l == 0) && n < 40) begin
         if (i2c_ack) begin i2c_req = 1'b0; got_i++; end
         if (lpc_ack) begin lpc_req = 1'b0; got_l++; end
         @(negedge clk);
         n++;
      end
      check("tie_i2c_served", got_i, 1);
      check("tie_lpc_served", got_l, 1);
      @(negedge clk);
   endtask

   vec_t vecs[8];

   initial begin
      int   n, first_grant;
      vec_t v;
      logic [7:0] e_err;

      vecs[0] = '{1'b0, 1'b0, 16'h0001, 16'h0004, 8'h00, 8'h5A, 8'h5A, 1'b0, 8'd0};
      vecs[1] = '{1'b1, 1'b0, 16'h0008, 16'h0001, 8'h00, 8'h3C, 8'h3C, 1'b0, 8'd0};
      vecs[2] = '{1'b1, 1'b1, 16'h0002, 16'h0010, 8'hC3, 8'h77, 8'h3C, 1'b0, 8'd0};
      vecs[3] = '{1'b0, 1'b1, 16'h8000, 16'h8000, 8'h11, 8'h99, 8'h5A, 1'b0, 8'd0};
      vecs[4] = '{1'b0, 1'b0, 16'h0003, 16'h0001, 8'h00, 8'h00, 8'hFF, 1'b1, 8'd1};
      vecs[5] = '{1'b1, 1'b1, 16'h0004, 16'h0000, 8'h00, 8'h00, 8'hFF, 1'b1, 8'd2};
      vecs[6] = '{1'b0, 1'b0, 16'h0100, 16'h0002, 8'h00, 8'hA5, 8'hA5, 1'b0, 8'd2};
      vecs[7] = '{1'b1, 1'b0, 16'h4000, 16'h0800, 8'h00, 8'h00, 8'h00, 1'b0, 8'd2};

      repeat (2) @(negedge clk);
      check("rst_i2c_ack", i2c_ack, 0);
      check("rst_lpc_ack", lpc_ack, 0);
      check("rst_i2c_rdata", i2c_rdata, 0);
      check("rst_lpc_rdata", lpc_rdata, 0);
      check("rst_port_cs", port_cs, 0);
      check("rst_offset", offset_sel, 0);
      check("rst_rd_wr", rd_wr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_owner", owner, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_lock_tmo", lock_tmo, 0);
      rst = 1'b0;
      @(negedge clk);

      // Ties: I2C wins the first (last_owner resets to LPC) and again after LPC was served.
      tie('{1'b0, 1'b0, 16'h0001, 16'h0001, 8'h00, 8'h21, 8'h21, 1'b0, 8'd0},
          '{1'b1, 1'b0, 16'h0002, 16'h0002, 8'h00, 8'h21, 8'h21, 1'b0, 8'd0}, 2'b01);
      tie('{1'b0, 1'b1, 16'h0010, 16'h0001, 8'hE7, 8'h42, 8'h21, 1'b0, 8'd0},
          '{1'b1, 1'b0, 16'h0020, 16'h0004, 8'h00, 8'h42, 8'h42, 1'b0, 8'd0}, 2'b01);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Lock: I2C owned last, lock held, LPC waiting.
      run_vec('{1'b0, 1'b0, 16'h0001, 16'h0001, 8'h00, 8'h66, 8'h66, 1'b0, 8'd2});
      v = '{1'b1, 1'b0, 16'h0400, 16'h0040, 8'h00, 8'h5C, 8'h5C, 1'b0, 8'd2};
      i2c_lock = 1'b1;
      drive(v);
      sb.push_back('{who: 1'b1, rdata: 8'h5C});
      n = 0;
      first_grant = 0;
      do begin
         @(negedge clk);
         n++;
         if (owner == 2'b10 && first_grant == 0) first_grant = n;
      end while (!lpc_ack && n < 60);
      check("lock_ack_seen", lpc_ack, 1);
`ifdef I2C_ARB_LOCK_EN
      check("lock_grant_cycle", first_grant, LockTmo + 1);
      check("lock_ack_cycle", n, LockTmo + 1 + RdLat);
      check("lock_tmo_set", lock_tmo, 1);
`else
      check("lock_grant_cycle", first_grant, 1);
      check("lock_ack_cycle", n, 1 + RdLat);
      check("lock_tmo_zero", lock_tmo, 0);
`endif
      lpc_req = 1'b0;
      i2c_lock = 1'b0;
      repeat (2) @(negedge clk);
`ifdef I2C_ARB_LOCK_EN
      check("lock_tmo_sticky", lock_tmo, 1);
`else
      check("lock_tmo_still_zero", lock_tmo, 0);
`endif

      // Saturating reject counter; the bus must stay silent throughout.
      bus_seen = 1'b0;
      e_err = 8'd2;
      for (int i = 0; i < 256; i++) begin
         e_err = (e_err == 8'hFF) ? 8'hFF : e_err + 8'd1;
         run_vec('{1'b0, 1'b0, 16'h0003, 16'h0001, 8'h00, 8'h00, 8'hFF, 1'b1, e_err});
      end
      check("err_cnt_saturated", err_cnt, 8'hFF);
      check("reject_bus_silent", bus_seen, 0);

      // Asynchronous reset in the middle of an access.
      drive('{1'b0, 1'b0, 16'h0200, 16'h0100, 8'h00, 8'h7E, 8'h00, 1'b0, 8'd0});
      @(negedge clk);
      check("pre_rst_port_cs", port_cs, 16'h0200);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_port_cs", port_cs, 0);
      check("mid_rst_offset", offset_sel, 0);
      check("mid_rst_owner", owner, 0);
      check("mid_rst_ack", i2c_ack, 0);
      i2c_req = 1'b0;
      @(negedge clk);
      check("mid_rst_ack_hold", i2c_ack, 0);
      check("mid_rst_err_cnt", err_cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      run_vec('{1'b0, 1'b0, 16'h0001, 16'h0008, 8'h00, 8'hB4, 8'hB4, 1'b0, 8'd0});
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
